// File: rtl/mlp_pkg.sv
// Constants shared by the weight loader and the core's weight-write decode.
package mlp_pkg;

    localparam int WT_DATA_W   = 16;
    localparam int WT_ADDR_W   = 7;
    localparam int WT_LSEL_LSB = 24;
    localparam int WT_ADDR_LSB = 16;
    localparam int NUM_LAYERS  = 4;
    localparam int WT_WORD_W   = 32;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_DRAIN = 2'd2
    } loader_state_e;

    // Write word layout: {4'h0, lsel[3:0], 1'b0, addr[6:0], data[15:0]}
    function automatic logic [WT_WORD_W-1:0] pack_word(
        input logic [NUM_LAYERS-1:0] lsel,
        input logic [WT_ADDR_W-1:0]  addr,
        input logic [WT_DATA_W-1:0]  data
    );
        logic [WT_WORD_W-1:0] w;
        w = '0;
        w[WT_LSEL_LSB +: NUM_LAYERS] = lsel;
        w[WT_ADDR_LSB +: WT_ADDR_W]  = addr;
        w[0 +: WT_DATA_W]            = data;
        return w;
    endfunction

endpackage

// File: rtl/mlp_weight_loader.sv
// Streams one AXI-Stream packet per MLP layer into addressed weight-write words,
// checking each packet length against the expected layer size.
module mlp_weight_loader
    import mlp_pkg::*;
#(
    parameter int L0_WORDS = 15,
    parameter int L1_WORDS = 24,
    parameter int L2_WORDS = 24,
    parameter int L3_WORDS = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [WT_DATA_W-1:0] s_tdata,
    input  logic                 s_tlast,
    output logic [WT_WORD_W-1:0] w_tdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    if (L0_WORDS < 1 || L0_WORDS > 128 || L1_WORDS < 1 || L1_WORDS > 128 ||
        L2_WORDS < 1 || L2_WORDS > 128 || L3_WORDS < 1 || L3_WORDS > 128) begin : g_bad_words
        $error("mlp_weight_loader: layer word counts must be within 1..128");
    end

    loader_state_e        state_q, state_d;
    logic [1:0]           layer_q, layer_d;
    logic [WT_ADDR_W-1:0] addr_q, addr_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [WT_WORD_W-1:0] w_tdata_q, w_tdata_d;

    logic [7:0]            n_words;
    logic                  last_addr;
    logic                  beat;
    logic [NUM_LAYERS-1:0] lsel;

    always_comb begin
        case (layer_q)
            2'd0:    n_words = 8'(L0_WORDS);
            2'd1:    n_words = 8'(L1_WORDS);
            2'd2:    n_words = 8'(L2_WORDS);
            default: n_words = 8'(L3_WORDS);
        endcase
    end

    assign last_addr = ({1'b0, addr_q} == (n_words - 8'd1));
    assign beat      = s_tvalid & s_tready;
    assign lsel      = NUM_LAYERS'(1) << layer_q;

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        addr_d    = addr_q;
        err_d     = err_q;
        done_d    = 1'b0;
        w_tdata_d = '0;
        // Abort outranks everything, including a beat accepted this cycle.
        if (abort) begin
            state_d = LD_IDLE;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (start) begin
                        state_d = LD_LOAD;
                        layer_d = 2'd0;
                        addr_d  = '0;
                        err_d   = 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (beat) begin
                        w_tdata_d = pack_word(lsel, addr_q, s_tdata);
                        if (s_tlast && last_addr) begin
                            addr_d = '0;
                            if (layer_q == 2'(NUM_LAYERS - 1)) begin
                                state_d = LD_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                layer_d = layer_q + 2'd1;
                            end
                        end else if (s_tlast) begin
                            err_d   = 1'b1;
                            state_d = LD_IDLE;
                        end else if (last_addr) begin
                            err_d   = 1'b1;
                            state_d = LD_DRAIN;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                LD_DRAIN: begin
                    if (beat && s_tlast) begin
                        state_d = LD_IDLE;
                    end
                end
                default: state_d = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= LD_IDLE;
            layer_q   <= 2'd0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            w_tdata_q <= '0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            done_q    <= done_d;
            w_tdata_q <= w_tdata_d;
        end
    end

    assign s_tready = (state_q != LD_IDLE);
    assign busy     = (state_q != LD_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign w_tdata  = w_tdata_q;

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Directed bench for mlp_weight_loader: full loads, length errors, abort and async reset.
module tb_mlp_weight_loader;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        s_tlast;
    logic [31:0] w_tdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int words[4] = '{15, 24, 24, 8};

    mlp_weight_loader dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (start),
        .abort    (abort),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .w_tdata  (w_tdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int l, input int i, input logic [15:0] d);
        logic [3:0] ls;
        logic [6:0] ad;
        ls = 4'(1 << l);
        ad = 7'(i);
        return {4'h0, ls, 1'b0, ad, d};
    endfunction

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, s_tready}, 32'd1);
        check("start_err_clr", {31'd0, err}, 32'd0);
    endtask

    // Sends n beats of layer l; tlast on beat index last_at (-1 = never); gap adds random idle cycles.
    task automatic load_layer(input int l, input int n, input int last_at, input bit gap);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                repeat ($urandom_range(0, 1)) begin
                    s_tvalid = 1'b0;
                    step();
                    check("idle_zero", w_tdata, 32'h0);
                end
            end
            d = 16'((l << 8) | i);
            if (l == 0 && i == 3) d = 16'hA5A5;
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tlast  = (i == last_at);
            start    = (l == 0 && i == 5);
            step();
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            start    = 1'b0;
            check($sformatf("word_l%0d_a%0d", l, i), w_tdata, exp_word(l, i, d));
            if (w_tdata[27:24] != 4'h0) writes++;
            if (l == 0 && i == 3) check("a5a5_word", w_tdata, 32'h0103A5A5);
        end
    endtask

    task automatic full_load(input bit gap, input string tag);
        writes = 0;
        do_start();
        for (int l = 0; l < 4; l++) begin
            load_layer(l, words[l], words[l] - 1, gap);
            if (l < 3) check({tag, "_mid_done"}, {31'd0, done}, 32'd0);
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_writes"}, 32'(writes), 32'd71);
        step();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_word"}, w_tdata, 32'h0);
        check({tag, "_idle_ready"}, {31'd0, s_tready}, 32'd0);
    endtask

    initial begin
        aresetn  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 16'h0;
        s_tlast  = 1'b0;
        #1;
        check("rst_word", w_tdata, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, s_tready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        step();
        aresetn = 1'b1;
        step();

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {31'd0, busy}, 32'd0);

        full_load(1'b0, "full");
        full_load(1'b1, "gaps");

        // short layer-1 packet: tlast at addr 9
        do_start();
        load_layer(0, 15, 14, 1'b0);
        load_layer(1, 10, 9, 1'b0);
        check("short_err", {31'd0, err}, 32'd1);
        check("short_busy", {31'd0, busy}, 32'd0);
        check("short_done", {31'd0, done}, 32'd0);
        step();
        check("short_done_late", {31'd0, done}, 32'd0);

        // next start clears err; abort at layer 1 addr 5 with a beat present
        do_start();
        load_layer(0, 15, 14, 1'b0);
        load_layer(1, 5, -1, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 16'hBEEF;
        abort    = 1'b1;
        step();
        s_tvalid = 1'b0;
        abort    = 1'b0;
        check("abort_word", w_tdata, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, s_tready}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);

        // long layer-2 packet: no tlast at addr 23, three discarded beats
        do_start();
        load_layer(0, 15, 14, 1'b0);
        load_layer(1, 24, 23, 1'b0);
        load_layer(2, 24, -1, 1'b0);
        check("long_err", {31'd0, err}, 32'd1);
        check("long_drain_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'h7000 + 16'(k);
            s_tlast  = (k == 2);
            step();
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            check($sformatf("drain_word_%0d", k), w_tdata, 32'h0);
        end
        check("long_idle", {31'd0, busy}, 32'd0);
        check("long_done", {31'd0, done}, 32'd0);
        check("long_err_kept", {31'd0, err}, 32'd1);

        // asynchronous reset mid-load
        do_start();
        load_layer(0, 4, -1, 1'b0);
        check("pre_rst_word", w_tdata, 32'h0103A5A5);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_word", w_tdata, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, s_tready}, 32'd0);
        aresetn = 1'b1;
        step();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
